// File: rtl/minbd_stage_one.sv
// minbd_stage_one: MinBD first stage; ejects one local flit, injects one queued flit, registers the four slots.
module minbd_stage_one #(
    parameter logic [1:0] MY_X = 2'd0,
    parameter logic [1:0] MY_Y = 2'd0,
    parameter int INJ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] n_in,
    input  logic [10:0] s_in,
    input  logic [10:0] e_in,
    input  logic [10:0] w_in,
    input  logic [10:0] inj_flit,
    input  logic        inj_valid,
    output logic        inj_ready,
    output logic [10:0] nty,
    output logic [10:0] sty,
    output logic [10:0] ety,
    output logic [10:0] wty,
    output logic [10:0] eject_flit,
    output logic        eject_valid
);
    localparam int AW = $clog2(INJ_DEPTH);
    logic [10:0] slot [4];
    logic [10:0] nxt [4];
    logic [3:0] match, rot, occ, avail;
    logic [1:0] rr_ptr, ej_off, ej_idx, ins_idx;
    logic ej_hit, full, empty, push, pop;
    logic [9:0] mem [INJ_DEPTH];
    logic [9:0] head;
    logic [AW:0] wptr, rptr;
    logic unused_valid_bit;
    // slots indexed in priority order N,E,S,W
    assign slot[0] = n_in;
    assign slot[1] = e_in;
    assign slot[2] = s_in;
    assign slot[3] = w_in;
    // the offered valid bit is irrelevant; queued flits are always stored as valid
    assign unused_valid_bit = inj_flit[10];
    genvar i;
    for (i = 0; i < 4; i++) begin : g_slot
        assign match[i] = slot[i][10] && slot[i][9:6] == {MY_X, MY_Y};
        assign rot[i] = match[rr_ptr + 2'(i)];
        assign occ[i] = slot[i][10] && !(ej_hit && ej_idx == 2'(i));
        assign nxt[i] = (pop && ins_idx == 2'(i)) ? {1'b1, head} : occ[i] ? slot[i] : '0;
    end
    assign ej_hit = |rot;
    assign ej_off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    assign ej_idx = rr_ptr + ej_off;
    assign avail = ~occ;
    assign ins_idx = avail[0] ? 2'd0 : avail[1] ? 2'd1 : avail[2] ? 2'd2 : 2'd3;
    assign full = (wptr ^ rptr) == (AW+1)'(INJ_DEPTH);
    assign empty = wptr == rptr;
    assign inj_ready = !full;
    assign push = inj_valid && !full;
    assign pop = !empty && |avail;
    assign head = mem[rptr[AW-1:0]];
    // injection queue storage, no reset needed since pointers qualify contents
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= inj_flit[9:0];
    end
    // register slots, ejected flit, round-robin pointer and queue pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nty <= '0;
            ety <= '0;
            sty <= '0;
            wty <= '0;
            eject_flit <= '0;
            eject_valid <= 1'b0;
            rr_ptr <= 2'd0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            nty <= nxt[0];
            ety <= nxt[1];
            sty <= nxt[2];
            wty <= nxt[3];
            eject_flit <= ej_hit ? slot[ej_idx] : '0;
            eject_valid <= ej_hit;
            rr_ptr <= ej_hit ? ej_idx + 2'd1 : rr_ptr;
            wptr <= push ? wptr + 1'b1 : wptr;
            rptr <= pop ? rptr + 1'b1 : rptr;
        end
    end
endmodule
